// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response plus the issue
// handshake toward execute and the branch controls coming back from decode.
interface pc_fetch_unit_if;
  // Memory side: imem_req/imem_addr are held stable until imem_ack is sampled high.
  // Issue side: instr/pc_out are held stable while instr_valid=1 until instr_ready=1;
  // an instruction transfers on any rising edge where both are high.
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] pc_out;
  logic        instr_ready;
  logic        BrTaken;
  logic        UncondBr;
  logic [25:0] br_addr26;
  logic [18:0] cond_addr19;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out,
    input  imem_ack, imem_rdata, instr_ready, BrTaken, UncondBr, br_addr26, cond_addr19
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out,
    output imem_ack, imem_rdata, instr_ready, BrTaken, UncondBr, br_addr26, cond_addr19
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: IDLE -> FETCH -> ISSUE loop, one instruction per two cycles at best.
// Optional BRANCH_COUNT_EN adds a saturating taken-branch counter on br_count.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pc_fetch_unit_if.master        bus,
  output logic [1:0]             state_dbg
`ifdef BRANCH_COUNT_EN
  ,
  output logic [31:0]            br_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] br_off;
  logic [63:0] next_pc;
  logic        accept;

  // Branch inputs only matter on the accepting ISSUE cycle; elsewhere next_pc is unused.
  always_comb begin
    br_off  = 64'd0;
    next_pc = 64'd0;
    if (bus.UncondBr) begin
      br_off = {{36{bus.br_addr26[25]}}, bus.br_addr26, 2'b00};
    end else begin
      br_off = {{43{bus.cond_addr19[18]}}, bus.cond_addr19, 2'b00};
    end
    next_pc = bus.BrTaken ? (pc + br_off) : (pc + 64'd4);
  end

  assign accept    = (state == ISSUE) && bus.instr_ready;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      bus.instr       <= 32'h0;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= RESET_PC;
      bus.instr_valid <= 1'b0;
      bus.pc_out      <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state         <= FETCH;
          bus.imem_req  <= 1'b1;
          bus.imem_addr <= pc;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            state           <= ISSUE;
            bus.instr       <= bus.imem_rdata;
            bus.pc_out      <= pc;
            bus.imem_req    <= 1'b0;
            bus.instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (accept) begin
            state           <= FETCH;
            pc              <= next_pc;
            bus.imem_req    <= 1'b1;
            bus.imem_addr   <= next_pc;
            bus.instr_valid <= 1'b0;
          end
        end
        default: begin
          state           <= IDLE;
          bus.imem_req    <= 1'b0;
          bus.instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_count <= 32'h0;
    end else if (accept && bus.BrTaken && (br_count != 32'hFFFF_FFFF)) begin
      br_count <= br_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: memory model with configurable wait states,
// per-scenario tasks with inline checks, and a single summary line.
module tb_pc_fetch_unit;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  state_dbg;
  int          errors = 0;
  int          checks = 0;
  int          ack_delay = 0;
  int          cnt = 0;
  logic        force_ack = 1'b0;
`ifdef BRANCH_COUNT_EN
  logic [31:0] br_count;
`endif

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.master),
    .state_dbg (state_dbg)
`ifdef BRANCH_COUNT_EN
    ,
    .br_count  (br_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory model: acks after ack_delay wait cycles; force_ack injects a stray response.
  always @(negedge clk) begin
    #1;
    if (force_ack) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hBAD0_BAD0;
      cnt = 0;
    end else if (reset_n === 1'b1 && bus.imem_req === 1'b1) begin
      if (cnt >= ack_delay) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        cnt = 0;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        cnt++;
      end
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
      cnt = 0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_req(output logic [63:0] a);
    a = 'x;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req === 1'b1) begin
        a = bus.imem_addr;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept(input logic br, input logic unc, input logic [25:0] o26, input logic [18:0] o19);
    bus.instr_ready = 1'b1;
    bus.BrTaken     = br;
    bus.UncondBr    = unc;
    bus.br_addr26   = o26;
    bus.cond_addr19 = o19;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.BrTaken     = 1'b0;
    bus.UncondBr    = 1'b0;
    bus.br_addr26   = 26'h0;
    bus.cond_addr19 = 19'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.imem_addr); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
    checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.instr); end
    checks++; if (bus.pc_out !== 64'h0) begin errors++; $display("FAIL reset_pc_out: got %h expected 0", bus.pc_out); end
`ifdef BRANCH_COUNT_EN
    checks++; if (br_count !== 32'h0) begin errors++; $display("FAIL reset_br_count: got %0d expected 0", br_count); end
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checks++; if (state_dbg !== S_IDLE || bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_cycle: state %0d req %b expected state 0 req 0", state_dbg, bus.imem_req); end
    @(negedge clk);
    checks++; if (state_dbg !== S_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin
      errors++; $display("FAIL first_fetch: state %0d req %b addr %h expected state 1 req 1 addr 0", state_dbg, bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc;
    ack_delay = 0;
    bus.instr_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_pc = 64'(4 * (k / 2));
      checks++; if (bus.imem_req !== ((k % 2) == 0)) begin errors++; $display("FAIL seq_req[%0d]: got %b", k, bus.imem_req); end
      checks++; if (bus.instr_valid !== ((k % 2) == 1)) begin errors++; $display("FAIL seq_valid[%0d]: got %b", k, bus.instr_valid); end
      if ((k % 2) == 0) begin
        checks++; if (bus.imem_addr !== exp_pc) begin errors++; $display("FAIL seq_addr[%0d]: got %h expected %h", k, bus.imem_addr, exp_pc); end
      end else begin
        checks++; if (bus.pc_out !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
          errors++; $display("FAIL seq_issue[%0d]: pc_out %h instr %h expected %h %h", k, bus.pc_out, bus.instr, exp_pc, mem_word(exp_pc));
        end
      end
      if (k == 5) bus.instr_ready = 1'b0;
    end
  endtask

  task automatic test_wait_states();
    ack_delay = 3;
    bus.instr_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0 || bus.instr_valid !== 1'b0) begin
        errors++; $display("FAIL wait_hold[%0d]: req %b addr %h valid %b expected 1 0 0", k, bus.imem_req, bus.imem_addr, bus.instr_valid);
      end
    end
    @(negedge clk);
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== mem_word(64'h0) || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL wait_capture: valid %b instr %h req %b expected 1 %h 0", bus.instr_valid, bus.instr, bus.imem_req, mem_word(64'h0));
    end
    ack_delay = 0;
  endtask

  task automatic test_branch();
    logic [63:0] a;
    bit ok;
    do_reset();
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL br_first_valid: got %b expected 1", ok); end
    accept(1'b1, 1'b0, 26'h0, 19'h40);
    wait_req(a);
    checks++; if (a !== 64'h100) begin errors++; $display("FAIL br_fwd_cond: got %h expected 100", a); end
    wait_valid(ok);
    checks++; if (bus.pc_out !== 64'h100 || bus.instr !== mem_word(64'h100)) begin
      errors++; $display("FAIL br_issue_100: pc_out %h instr %h", bus.pc_out, bus.instr);
    end
    accept(1'b1, 1'b1, 26'h3FF_FFFF, 19'h0);
    wait_req(a);
    checks++; if (a !== 64'hFC) begin errors++; $display("FAIL br_back_uncond: got %h expected fc", a); end
    wait_valid(ok);
    accept(1'b1, 1'b0, 26'h0, 19'h7FFD1);
    wait_req(a);
    checks++; if (a !== 64'h40) begin errors++; $display("FAIL br_back_cond: got %h expected 40", a); end
    wait_valid(ok);
    accept(1'b1, 1'b0, 26'h0, 19'd4);
    wait_req(a);
    checks++; if (a !== 64'h50) begin errors++; $display("FAIL br_cond_4: got %h expected 50", a); end
    wait_valid(ok);
    accept(1'b1, 1'b1, 26'h0, 19'h0);
    wait_req(a);
    checks++; if (a !== 64'h50) begin errors++; $display("FAIL br_zero_off: got %h expected 50", a); end
    wait_valid(ok);
    accept(1'b0, 1'b1, 26'h155, 19'h7);
    wait_req(a);
    checks++; if (a !== 64'h54) begin errors++; $display("FAIL br_not_taken: got %h expected 54", a); end
  endtask

  task automatic test_stall();
    logic [63:0] a;
    bit ok;
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_enter: got %b expected 1", ok); end
    for (int k = 0; k < 5; k++) begin
      bus.BrTaken     = (k % 2) == 0;
      bus.UncondBr    = (k % 2) == 1;
      bus.br_addr26   = 26'(k * 37 + 5);
      bus.cond_addr19 = 19'(k * 11 + 3);
      force_ack = (k == 2);
      @(negedge clk);
      checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hs[%0d]: valid %b req %b expected 1 0", k, bus.instr_valid, bus.imem_req);
      end
      checks++; if (bus.pc_out !== 64'h54 || bus.instr !== mem_word(64'h54)) begin
        errors++; $display("FAIL stall_hold[%0d]: pc_out %h instr %h expected 54 %h", k, bus.pc_out, bus.instr, mem_word(64'h54));
      end
    end
    force_ack = 1'b0;
    accept(1'b0, 1'b0, 26'h0, 19'h0);
    wait_req(a);
    checks++; if (a !== 64'h58) begin errors++; $display("FAIL stall_release: got %h expected 58", a); end
  endtask

  task automatic test_wrap();
    logic [63:0] a;
    bit ok;
    do_reset();
    wait_valid(ok);
    accept(1'b1, 1'b0, 26'h0, 19'h7FFFF);
    wait_req(a);
    checks++; if (a !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_back: got %h expected fffffffffffffffc", a); end
    wait_valid(ok);
    accept(1'b0, 1'b0, 26'h0, 19'h0);
    wait_req(a);
    checks++; if (a !== 64'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected 0", a); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [63:0] a;
    bit ok;
    ack_delay = 0;
    do_reset();
    wait_valid(ok);
    ack_delay = 10;
    accept(1'b1, 1'b0, 26'h0, 19'h80);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h200) begin
      errors++; $display("FAIL mid_fetch_pre: req %b addr %h expected 1 200", bus.imem_req, bus.imem_addr);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (state_dbg !== S_IDLE || bus.imem_req !== 1'b0 || bus.imem_addr !== 64'h0) begin
      errors++; $display("FAIL mid_fetch_abort: state %0d req %b addr %h expected 0 0 0", state_dbg, bus.imem_req, bus.imem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    force_ack = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    force_ack = 1'b0;
    checks++; if (state_dbg !== S_FETCH || bus.imem_addr !== 64'h0 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL restart_fetch: state %0d addr %h valid %b expected 1 0 0", state_dbg, bus.imem_addr, bus.instr_valid);
    end
    wait_valid(ok);
    checks++; if (bus.instr !== mem_word(64'h0) || bus.pc_out !== 64'h0) begin
      errors++; $display("FAIL restart_instr: instr %h pc_out %h expected %h 0", bus.instr, bus.pc_out, mem_word(64'h0));
    end
`ifdef BRANCH_COUNT_EN
    checks++; if (br_count !== 32'd0) begin errors++; $display("FAIL brc_after_reset: got %0d expected 0", br_count); end
    accept(1'b1, 1'b0, 26'h0, 19'd1);
    wait_valid(ok);
    accept(1'b0, 1'b0, 26'h0, 19'h0);
    wait_valid(ok);
    accept(1'b1, 1'b1, 26'd1, 19'h0);
    checks++; if (br_count !== 32'd2) begin errors++; $display("FAIL brc_two_taken: got %0d expected 2", br_count); end
    wait_req(a);
    checks++; if (a !== 64'hC) begin errors++; $display("FAIL brc_addr: got %h expected c", a); end
`else
    accept(1'b1, 1'b0, 26'h0, 19'd1);
    wait_req(a);
    checks++; if (a !== 64'h4) begin errors++; $display("FAIL restart_branch: got %h expected 4", a); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_ready = 1'b0;
    bus.BrTaken     = 1'b0;
    bus.UncondBr    = 1'b0;
    bus.br_addr26   = 26'h0;
    bus.cond_addr19 = 19'h0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch();
    test_stall();
    test_wrap();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
